// File: rtl/memory_system_pkg.sv
// Shared types for the memory port arbiter.
//   DATA_WIDTH_DEF : default address/data width
//   state_e        : transaction sequencer states
//   req_id_e       : requester identity (fetch = 0, loader = 1)
//   txn_ctl_t      : control fields latched from the winning request
package memory_system_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_id_e;

  typedef struct packed {
    req_id_e owner;
    logic    we;
  } txn_ctl_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i[1:0] : requests, bit 0 = fetch, bit 1 = loader
//   enable_i   : grants are issued only while high
//   gnt_o[1:0] : one-hot grant, combinational from req_i
// last_q remembers the previous winner; on contention the other side wins.
module rr_arbiter_2
  import memory_system_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] gnt_o
);

  req_id_e last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (enable_i) begin
      if (req_i == 2'b11) gnt_o = (last_q == REQ_LOAD) ? 2'b01 : 2'b10;
      else                gnt_o = req_i;
    end
  end

  // Reset to loader so that fetch wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= REQ_LOAD;
    else if (|gnt_o) last_q <= gnt_o[1] ? REQ_LOAD : REQ_FETCH;
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Sequences the single memory_system port between instruction fetch (read
// only) and the loader/debug port (read or write), one access at a time.
//   clk, rst_n          : clock, asynchronous active-low reset
//   fetch_*             : fetch request/grant/read-data return
//   load_*              : loader request/grant/completion return
//   mem_we_o/addr/wdata : registered drives to memory_system
//   mem_rdata_i         : read data, valid READ_LATENCY cycles after address
// Flow: IDLE (grant, latch) -> ISSUE (drive port) -> [WAIT] -> RESP (rvalid).
module memory_port_arbiter
  import memory_system_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int MEMORY_DEPTH = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req_i,
  input  logic [DATA_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_gnt_o,
  output logic                  fetch_rvalid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  input  logic                  load_req_i,
  input  logic                  load_we_i,
  input  logic [DATA_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_wdata_i,
  output logic                  load_gnt_o,
  output logic                  load_rvalid_o,
  output logic [DATA_WIDTH-1:0] load_rdata_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  // WAIT counts down from READ_LATENCY-1 so capture lands in N+1+READ_LATENCY.
  localparam logic [1:0] LAT_LOAD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  if (READ_LATENCY < 0 || READ_LATENCY > 3 || MEMORY_DEPTH < 1) begin : g_param_check
    $error("memory_port_arbiter: READ_LATENCY must be 0..3, MEMORY_DEPTH positive");
  end

  state_e                state_q;
  txn_ctl_t              ctl_q;
  logic [1:0]            cnt_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_wdata_q;
  logic [DATA_WIDTH-1:0] fetch_rdata_q, load_rdata_q;
  logic                  fetch_rvalid_q, load_rvalid_q;
  logic [1:0]            req, gnt;
  logic                  arb_en;
  logic                  cap_now;

  assign req    = {load_req_i, fetch_req_i};
  assign arb_en = (state_q == IDLE);

  rr_arbiter_2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .enable_i (arb_en),
    .gnt_o    (gnt)
  );

  // Read data is sampled at the end of ISSUE (zero latency) or the last WAIT cycle.
  assign cap_now = !ctl_q.we &&
                   (((state_q == ISSUE) && (READ_LATENCY == 0)) ||
                    ((state_q == WAIT) && (cnt_q == 2'd0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ctl_q          <= '0;
      cnt_q          <= 2'd0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      fetch_rdata_q  <= '0;
      load_rdata_q   <= '0;
      fetch_rvalid_q <= 1'b0;
      load_rvalid_q  <= 1'b0;
    end else begin
      fetch_rvalid_q <= 1'b0;
      load_rvalid_q  <= 1'b0;
      case (state_q)
        IDLE: if (|gnt) begin
          state_q     <= ISSUE;
          ctl_q.owner <= gnt[1] ? REQ_LOAD : REQ_FETCH;
          ctl_q.we    <= gnt[1] & load_we_i;
          mem_we_q    <= gnt[1] & load_we_i;
          mem_addr_q  <= gnt[1] ? load_addr_i : fetch_addr_i;
          mem_wdata_q <= gnt[1] ? load_wdata_i : '0;
        end
        ISSUE: begin
          mem_we_q <= 1'b0;
          if (ctl_q.we) begin
            // Writes always belong to the loader; completion returns zero data.
            state_q       <= RESP;
            load_rvalid_q <= 1'b1;
            load_rdata_q  <= '0;
          end else if (READ_LATENCY == 0) begin
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
            cnt_q   <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 2'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (cap_now) begin
        if (ctl_q.owner == REQ_LOAD) begin
          load_rdata_q  <= mem_rdata_i;
          load_rvalid_q <= 1'b1;
        end else begin
          fetch_rdata_q  <= mem_rdata_i;
          fetch_rvalid_q <= 1'b1;
        end
      end
    end
  end

  assign fetch_gnt_o    = gnt[0];
  assign load_gnt_o     = gnt[1];
  assign fetch_rvalid_o = fetch_rvalid_q;
  assign load_rvalid_o  = load_rvalid_q;
  assign fetch_rdata_o  = fetch_rdata_q;
  assign load_rdata_o   = load_rdata_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;

endmodule
